// File: rtl/map_scan_mux.sv
// Registered N-channel display-map selector.
// Manual mode shows the selected map; scan mode rotates through all maps,
// dwelling DWELL cycles on each. hold freezes every piece of state.
module map_scan_mux #(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL    = 50000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*CHANNELS-1:0] maps,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      scan_en,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      tick
);

    // Counter only ever reaches DWELL-1; the extra headroom keeps DWELL=1 legal.
    localparam int unsigned CntW = $clog2(DWELL + 1);

    typedef enum logic [0:0] {StManual, StScan} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                tick_q, tick_d;
    logic                sel_valid;
    logic                dwell_done;
    logic [WIDTH-1:0]    map_arr [CHANNELS];

    // Unpack the flat map bus into one entry per channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign map_arr[k] = maps[k*WIDTH +: WIDTH];
    end

    assign sel_valid  = (32'(sel) < CHANNELS);
    assign dwell_done = (cnt_q == CntW'(DWELL - 1));

    // Next-state: mode transitions, dwell counting and channel selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        if (!hold) begin
            unique case (state_q)
                StManual: begin
                    cnt_d = '0;
                    if (scan_en) begin
                        // Scanning resumes from the channel already on display.
                        state_d = StScan;
                    end else if (sel_valid) begin
                        sel_d = sel;
                    end
                end
                StScan: begin
                    if (!scan_en) begin
                        state_d = StManual;
                        cnt_d   = '0;
                        if (sel_valid) begin
                            sel_d = sel;
                        end
                    end else if (dwell_done) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        sel_d  = (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StManual;
            endcase
            // Reload every active edge so live map edits reach the display.
            out_d = map_arr[sel_d];
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StManual;
            cnt_q   <= '0;
            sel_q   <= '0;
            out_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign out     = out_q;
    assign cur_sel = sel_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_map_scan_mux.sv
// Bench for map_scan_mux: a 4-channel and a 3-channel instance share stimulus
// and are compared against a per-instance reference model after every edge.
module tb_map_scan_mux;

    localparam int unsigned W  = 7;
    localparam int unsigned DW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*W-1:0]  maps;
    logic [1:0]      sel;
    logic            scan_en;
    logic            hold;
    logic [W-1:0]    out4, out3;
    logic [1:0]      cs4, cs3;
    logic            tk4, tk3;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = 4-channel instance, 1 = 3-channel.
    int unsigned m_scan [2];
    int unsigned m_idx  [2];
    int unsigned m_el   [2];
    int unsigned m_out  [2];
    int unsigned m_tk   [2];

    always #5 clk = ~clk;

    map_scan_mux #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .DWELL(DW)) dut4 (
        .clk(clk), .reset(reset), .maps(maps), .sel(sel), .scan_en(scan_en),
        .hold(hold), .out(out4), .cur_sel(cs4), .tick(tk4)
    );

    map_scan_mux #(.WIDTH(W), .CHANNELS(3), .SEL_W(2), .DWELL(DW)) dut3 (
        .clk(clk), .reset(reset), .maps(maps[3*W-1:0]), .sel(sel), .scan_en(scan_en),
        .hold(hold), .out(out3), .cur_sel(cs3), .tick(tk3)
    );

    function automatic int unsigned map_of(int unsigned ch);
        return (maps >> (ch * W)) & ((1 << W) - 1);
    endfunction

    // Behaviour at one rising edge, from the rules: elapsed cycles in the
    // current dwell, rotate modulo the channel count when a dwell completes.
    task automatic model_edge(input int i, input int unsigned nch);
        if (reset) begin
            m_scan[i] = 0; m_idx[i] = 0; m_el[i] = 0; m_out[i] = 0; m_tk[i] = 0;
        end else if (hold) begin
            m_tk[i] = 0;
        end else begin
            m_tk[i] = 0;
            if (m_scan[i] == 0 && scan_en) begin
                m_scan[i] = 1;
                m_el[i]   = 0;
            end else if (!scan_en) begin
                m_scan[i] = 0;
                m_el[i]   = 0;
                if (sel < nch) m_idx[i] = sel;
            end else begin
                m_el[i] = m_el[i] + 1;
                if (m_el[i] == DW) begin
                    m_el[i]  = 0;
                    m_idx[i] = (m_idx[i] + 1) % nch;
                    m_tk[i]  = 1;
                end
            end
            m_out[i] = map_of(m_idx[i]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model, then check both instances.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(0, 4);
        model_edge(1, 3);
        #1;
        chk({tag, "/out4"}, 32'(out4), m_out[0]);
        chk({tag, "/sel4"}, 32'(cs4), m_idx[0]);
        chk({tag, "/tick4"}, 32'(tk4), m_tk[0]);
        chk({tag, "/out3"}, 32'(out3), m_out[1]);
        chk({tag, "/sel3"}, 32'(cs3), m_idx[1]);
        chk({tag, "/tick3"}, 32'(tk3), m_tk[1]);
    endtask

    initial begin
        logic found;
        reset   = 1'b1;
        hold    = 1'b0;
        scan_en = 1'b0;
        sel     = 2'd0;
        maps    = {7'b1111111, 7'b0011100, 7'b1100011, 7'b1000001};

        // Reset for two edges, then release into manual channel 0.
        step("reset0");
        step("reset1");
        chk("reset_out_const", 32'(out4), 32'd0);
        #3 reset = 1'b0;
        step("release");
        chk("release_out_const", 32'(out4), 32'b1000001);

        // Manual selection; sel=3 is out of range for the 3-channel instance.
        sel = 2'd2; step("man2");
        chk("man2_out_const", 32'(out4), 32'b0011100);
        sel = 2'd1; step("man1");
        sel = 2'd3; step("man3");
        chk("oor_sel3_kept", 32'(cs3), 32'd1);
        sel = 2'd1; step("man1b");

        // Scan rotation starting from channel 1.
        scan_en = 1'b1;
        for (int n = 0; n < 10; n++) step("scan");
        chk("scan_end_sel", 32'(cs4), 32'd0);

        // Hold mid-dwell, one cycle after a tick.
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            step("seek_tick");
            found = tk4;
        end
        chk("tick_seen", 32'(found), 32'd1);
        step("post_tick");
        hold = 1'b1;
        for (int n = 0; n < 5; n++) step("hold");
        hold = 1'b0;
        step("rel1");
        chk("rel1_no_tick", 32'(tk4), 32'd0);
        step("rel2");
        chk("rel2_tick", 32'(tk4), 32'd1);

        // Live map edit in manual, then frozen under hold.
        scan_en = 1'b0;
        sel = 2'd3;
        maps[3*W +: W] = 7'b0000000;
        step("live0");
        hold = 1'b1;
        maps[3*W +: W] = 7'b1010101;
        step("live_hold0");
        step("live_hold1");
        chk("live_frozen", 32'(out4), 32'd0);
        hold = 1'b0;
        step("live_rel");
        chk("live_rel_out", 32'(out4), 32'b1010101);

        // Reset mid-scan with hold and scan_en both high.
        scan_en = 1'b1;
        step("pre_rst0");
        step("pre_rst1");
        hold  = 1'b1;
        reset = 1'b1;
        step("rst_mid");
        reset = 1'b0;
        step("rst_hold0");
        step("rst_hold1");
        hold = 1'b0;
        for (int n = 0; n < 6; n++) step("rst_scan");

        // Randomised traffic across all controls.
        for (int n = 0; n < 300; n++) begin
            sel     = 2'($urandom_range(0, 3));
            scan_en = ($urandom_range(0, 9) < 7);
            hold    = ($urandom_range(0, 9) < 2);
            reset   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 4) == 0) maps = 28'($urandom());
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
